systolic_array_os: RTL and testbench
====================================

// Module: systolic_array_os
// PURPOSE
//  Parametrised NxN output-stationary systolic array computing C = A*B (A: NxK, B: KxN), signed.
//  Input skew, PE grid, drain and result read-out are all internal to the block.
//  Sits between the operand-fetch streamer (one A column + one B row per beat) and the result writer.
//  Results are read out row by row over a valid/ready port.
// PARAMETERS
//  N       3   array dimension (rows = cols = N), N >= 2
//  DATA_W  8   signed operand width
//  ACC_W   24  signed accumulator width per PE
//  MAX_K   64  largest supported inner dimension K
//  KW      $clog2(MAX_K+1)  width of k_len (derived, not overridden)
// PORTS
//  clk        in   1         rising-edge clock
//  reset_n    in   1         asynchronous reset, active-low
//  start      in   1         begin a job (sampled only in IDLE)
//  k_len      in   KW        inner dimension K for the job, sampled with start
//  in_valid   in   1         a_vec/b_vec beat valid
//  in_ready   out  1         block accepts a beat
//  a_vec      in   N*DATA_W  A[i][k] for i=0..N-1; element i at bits [i*DATA_W +: DATA_W]
//  b_vec      in   N*DATA_W  B[k][j] for j=0..N-1, same packing
//  out_valid  out  1         out_row holds a result row
//  out_ready  in   1         consumer takes the row
//  out_idx    out  $clog2(N) row index i of out_row
//  out_row    out  N*ACC_W   C[i][j] for j=0..N-1; element j at bits [j*ACC_W +: ACC_W]
//  busy       out  1         high in every state except IDLE
//  done       out  1         one-cycle pulse after the last row is accepted
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE; all PE accumulators, skew registers and counters = 0;
//    in_ready=0, out_valid=0, out_idx=0, out_row=0, busy=0, done=0. Reset mid-job aborts the job.
//  - FSM: IDLE -> STREAM -> DRAIN -> OUT -> IDLE.
//  - IDLE: start=1 clears all accumulators, latches k_len, enters STREAM next cycle.
//    k_len=0 goes straight to OUT (all results 0). start outside IDLE is ignored.
//  - STREAM: in_ready=1. An accepted beat (in_valid & in_ready) enters the skew.
//    Row i of A is delayed i cycles; column j of B is delayed j cycles.
//    A cycle with in_valid=0 injects zeros; the array still advances.
//    After the K-th accepted beat, in_ready drops in the same cycle and state -> DRAIN.
//  - PE(i,j): acc += a*b every cycle (full 2*DATA_W product, sign-extended to ACC_W);
//    a passes right, b passes down, one register stage each.
//    Default accumulation wraps modulo 2^ACC_W.
//  - DRAIN: zeros injected for exactly 2N-1 cycles, so the last product reaches PE(N-1,N-1); then OUT.
//  - OUT: out_valid=1 with out_idx=0 first. Row advances on out_valid & out_ready.
//    out_row/out_idx are held stable while out_ready=0.
//    The cycle after row N-1 is accepted: out_valid=0, done=1 for one cycle, state=IDLE.
//  - Latency (no bubbles, out_ready=1): first out_valid = K + 2N - 1 cycles after the STREAM entry cycle.
// CONFIGURATION
//  SYSTOLIC_SATURATE_EN defined:
//    PE accumulators saturate to +(2^(ACC_W-1)-1) / -(2^(ACC_W-1)) and do not wrap.
//    A sticky 1-bit port `sat_flag` (out) is added; it is set if any PE saturated
//    and is cleared on start or reset.
//  Undefined: accumulators wrap modulo 2^ACC_W and the sat_flag port does not exist.
// TESTING
//  1. N=3, K=3, A=identity, B=[[1,2,3],[4,5,6],[7,8,9]] -> rows out = B, out_idx 0,1,2, then done pulse.
//  2. N=3, K=2, A=[[1,2],[3,4],[5,6]], B=[[1,-1,2],[0,3,-2]]
//     -> rows [1,5,-2], [3,9,-2], [5,13,-2]; first out_valid exactly 7 cycles after the STREAM entry cycle.
//  3. Case 2 with in_valid low on alternate cycles -> identical results; in_ready drops only after the 2nd beat.
//  4. out_ready held low 5 cycles per row -> each row and its index stay stable; no row lost or repeated;
//     start pulsed during OUT is ignored.
//  5. DATA_W=8, ACC_W=16, K=4, all operands -128 (sum 65536)
//     -> wraps to 0 by default; with SYSTOLIC_SATURATE_EN gives 32767 and sat_flag=1.
//  6. reset_n pulsed low mid-STREAM -> all outputs 0 immediately, IDLE;
//     a new job then gives case-1 results; k_len=0 job -> 3 zero rows, then done.

Source files
------------

// File: rtl/systolic_array_os.sv
// NxN output-stationary signed systolic multiplier C = A*B: input skew, PE grid, drain, row read-out.
// Build option SYSTOLIC_SATURATE_EN: saturating accumulators plus a sticky sat_flag output.
module systolic_array_os #(
  parameter  int N      = 3,
  parameter  int DATA_W = 8,
  parameter  int ACC_W  = 24,
  parameter  int MAX_K  = 64,
  localparam int KW     = $clog2(MAX_K + 1),
  localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [KW-1:0]       k_len,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] a_vec,
  input  logic [N*DATA_W-1:0] b_vec,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IW-1:0]       out_idx,
  output logic [N*ACC_W-1:0]  out_row,
  output logic                busy,
  output logic                done,
`ifdef SYSTOLIC_SATURATE_EN
  output logic                sat_flag,
`endif
  output logic [1:0]          fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // valid never depends on ready, and the producer holds its data while valid & !ready.
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DRAIN = 2'd2, OUT = 2'd3} state_t;
  localparam int DCW = $clog2(2 * N);

  state_t         state, state_next;
  logic [KW-1:0]  k_lat, k_cnt;
  logic [DCW-1:0] drain_cnt;
  logic [IW-1:0]  row_cnt;
  logic           clr, accept, run, take, last_beat, last_drain, last_row;

  logic signed [DATA_W-1:0] a_h [N][N];
  logic signed [DATA_W-1:0] b_h [N][N];
  logic signed [ACC_W-1:0]  acc [N][N];
`ifdef SYSTOLIC_SATURATE_EN
  logic [N*N-1:0] sat_hit;
`endif

  assign clr        = (state == IDLE) && start;
  assign in_ready   = (state == STREAM);
  assign accept     = in_valid && in_ready;
  assign run        = (state == STREAM) || (state == DRAIN);
  assign out_valid  = (state == OUT);
  assign take       = out_valid && out_ready;
  assign busy       = (state != IDLE);
  assign last_beat  = (k_cnt + KW'(1)) == k_lat;
  assign last_drain = drain_cnt == DCW'(2 * N - 2);
  assign last_row   = row_cnt == IW'(N - 1);
  assign out_idx    = row_cnt;
  assign fsm_state  = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (k_len == '0) ? OUT : STREAM;
      STREAM:  if (accept && last_beat) state_next = DRAIN;
      DRAIN:   if (last_drain) state_next = OUT;
      OUT:     if (take && last_row) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_lat     <= '0;
      k_cnt     <= '0;
      drain_cnt <= '0;
      row_cnt   <= '0;
      done      <= 1'b0;
    end else begin
      done <= take && last_row;
      if (clr) begin
        k_lat     <= k_len;
        k_cnt     <= '0;
        drain_cnt <= '0;
        row_cnt   <= '0;
      end else begin
        if (accept) k_cnt <= k_cnt + KW'(1);
        if (state == DRAIN) drain_cnt <= drain_cnt + DCW'(1);
        if (take) row_cnt <= last_row ? '0 : row_cnt + IW'(1);
      end
    end
  end

  // Skew: row i of A and column i of B enter the grid i cycles late; idle cycles inject zeros.
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic signed [DATA_W-1:0] a_new, b_new;
    assign a_new = accept ? a_vec[i*DATA_W +: DATA_W] : '0;
    assign b_new = accept ? b_vec[i*DATA_W +: DATA_W] : '0;
    if (i == 0) begin : g_direct
      assign a_h[0][0] = a_new;
      assign b_h[0][0] = b_new;
    end else begin : g_delay
      logic signed [DATA_W-1:0] a_d [i];
      logic signed [DATA_W-1:0] b_d [i];
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int d = 0; d < i; d++) begin
            a_d[d] <= '0;
            b_d[d] <= '0;
          end
        end else if (clr) begin
          for (int d = 0; d < i; d++) begin
            a_d[d] <= '0;
            b_d[d] <= '0;
          end
        end else begin
          a_d[0] <= a_new;
          b_d[0] <= b_new;
          for (int d = 1; d < i; d++) begin
            a_d[d] <= a_d[d-1];
            b_d[d] <= b_d[d-1];
          end
        end
      end
      assign a_h[i][0] = a_d[i-1];
      assign b_h[0][i] = b_d[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic signed [2*DATA_W-1:0] prod;
      logic signed [ACC_W-1:0]    acc_q, acc_next;
      assign prod = (2*DATA_W)'(a_h[i][j]) * (2*DATA_W)'(b_h[i][j]);
`ifdef SYSTOLIC_SATURATE_EN
      logic signed [ACC_W:0] sum;
      logic                  ovf;
      assign sum  = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod);
      assign ovf  = sum[ACC_W] != sum[ACC_W-1];
      assign sat_hit[i*N+j] = run && ovf;
      always_comb begin
        acc_next = sum[ACC_W-1:0];
        if (ovf) acc_next = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
`else
      assign acc_next = acc_q + ACC_W'(prod);
`endif
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  acc_q <= '0;
        else if (clr)  acc_q <= '0;
        else if (run)  acc_q <= acc_next;
      end
      assign acc[i][j] = acc_q;

      if (j < N - 1) begin : g_pass_a
        logic signed [DATA_W-1:0] a_q;
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) a_q <= '0;
          else if (clr) a_q <= '0;
          else          a_q <= a_h[i][j];
        end
        assign a_h[i][j+1] = a_q;
      end
      if (i < N - 1) begin : g_pass_b
        logic signed [DATA_W-1:0] b_q;
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) b_q <= '0;
          else if (clr) b_q <= '0;
          else          b_q <= b_h[i][j];
        end
        assign b_h[i+1][j] = b_q;
      end
    end
  end

`ifdef SYSTOLIC_SATURATE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      sat_flag <= 1'b0;
    else if (clr)      sat_flag <= 1'b0;
    else if (|sat_hit) sat_flag <= 1'b1;
  end
`endif

  // Accumulators are frozen in OUT, so the selected row stays stable while stalled.
  always_comb begin
    out_row = '0;
    if (state == OUT) begin
      for (int j = 0; j < N; j++) out_row[j*ACC_W +: ACC_W] = acc[row_cnt][j];
    end
  end

endmodule

// File: tb/tb_systolic_array_os.sv
// Bench for systolic_array_os: directed table, randomized jobs vs. a plain matrix-product model,
// reset/stall/zero-K corner cases, and a narrow-accumulator instance for wrap or saturation.
module tb_systolic_array_os;
  localparam int N    = 3;
  localparam int DW   = 8;
  localparam int AW   = 24;
  localparam int MAXK = 64;
  localparam int KW   = $clog2(MAXK + 1);
  localparam int IW   = $clog2(N);
  localparam int VW   = N * DW;
  localparam int RW   = N * AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic [VW-1:0] a_vec = '0, b_vec = '0;
  logic          in_ready, out_valid, busy, done;
  logic [IW-1:0] out_idx;
  logic [RW-1:0] out_row;
  logic [1:0]    fsm_state;

  logic          d2_start = 1'b0, d2_in_valid = 1'b0, d2_out_ready = 1'b0;
  logic [KW-1:0] d2_k_len = '0;
  logic [15:0]   d2_a = '0, d2_b = '0;
  logic          d2_in_ready, d2_out_valid, d2_busy, d2_done;
  logic [0:0]    d2_out_idx;
  logic [31:0]   d2_out_row;
  logic [1:0]    d2_state;
`ifdef SYSTOLIC_SATURATE_EN
  logic sat_flag, d2_sat_flag;
`endif

  systolic_array_os #(.N(N), .DATA_W(DW), .ACC_W(AW), .MAX_K(MAXK)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_row(out_row),
    .busy(busy), .done(done),
`ifdef SYSTOLIC_SATURATE_EN
    .sat_flag(sat_flag),
`endif
    .fsm_state(fsm_state)
  );

  systolic_array_os #(.N(2), .DATA_W(8), .ACC_W(16), .MAX_K(MAXK)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(d2_start), .k_len(d2_k_len),
    .in_valid(d2_in_valid), .in_ready(d2_in_ready), .a_vec(d2_a), .b_vec(d2_b),
    .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_idx(d2_out_idx), .out_row(d2_out_row),
    .busy(d2_busy), .done(d2_done),
`ifdef SYSTOLIC_SATURATE_EN
    .sat_flag(d2_sat_flag),
`endif
    .fsm_state(d2_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [RW-1:0] exp_q[$];
  logic [VW-1:0] a_beats[MAXK];
  logic [VW-1:0] b_beats[MAXK];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [VW-1:0] v3(input int x0, input int x1, input int x2);
    logic [31:0] t0, t1, t2;
    t0 = x0; t1 = x1; t2 = x2;
    return {t2[DW-1:0], t1[DW-1:0], t0[DW-1:0]};
  endfunction

  function automatic logic [RW-1:0] r3(input int c0, input int c1, input int c2);
    logic [31:0] t0, t1, t2;
    t0 = c0; t1 = c1; t2 = c2;
    return {t2[AW-1:0], t1[AW-1:0], t0[AW-1:0]};
  endfunction

  // Reference: C[i][j] = sum_k A[i][k]*B[k][j], reduced modulo 2^AW.
  function automatic void model_push(input int k);
    for (int i = 0; i < N; i++) begin
      logic [RW-1:0] row;
      row = '0;
      for (int j = 0; j < N; j++) begin
        longint s;
        logic [63:0] su;
        s = 0;
        for (int kk = 0; kk < k; kk++) begin
          int av, bv;
          av = int'($signed(a_beats[kk][i*DW +: DW]));
          bv = int'($signed(b_beats[kk][j*DW +: DW]));
          s += longint'(av * bv);
        end
        su = s;
        row[j*AW +: AW] = su[AW-1:0];
      end
      exp_q.push_back(row);
    end
  endfunction

  // ---------------- driver ----------------
  task automatic run_job(input string tag, input int k, input bit gap, input bit stall, input int exp_lat);
    int cyc, beats, rows, hold, first_ov;
    bit fin;
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(k);
    @(negedge clk);
    start = 1'b0;
    cyc = 0; beats = 0; rows = 0; hold = 0; first_ov = -1; fin = 1'b0;
    while (!fin && cyc < 1000) begin
      if (!out_valid && rows == 0)
        check({tag, " in_ready"}, 128'(in_ready), 128'(beats < k));
      if (in_ready && beats < k && !(gap && (cyc % 2) == 1)) begin
        in_valid = 1'b1;
        a_vec = a_beats[beats];
        b_vec = b_beats[beats];
        beats++;
      end else begin
        in_valid = in_ready ? 1'b0 : 1'($urandom_range(0, 1));
        a_vec = VW'($urandom);
        b_vec = VW'($urandom);
      end
      out_ready = 1'b0;
      start = 1'b0;
      if (out_valid) begin
        if (first_ov < 0) first_ov = cyc;
        check($sformatf("%s out_idx r%0d", tag, rows), 128'(out_idx), 128'(rows));
        if (exp_q.size() > 0) check($sformatf("%s row%0d", tag, rows), 128'(out_row), 128'(exp_q[0]));
        if (stall && hold < 5) begin
          hold++;
          if (hold == 2) begin
            start = 1'b1;
            k_len = KW'(5);
          end
        end else begin
          out_ready = 1'b1;
          hold = 0;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          rows++;
          if (rows == N) fin = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    if (!fin) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: rows=%0d, expected %0d", tag, rows, N);
    end
    check({tag, " done"}, 128'(done), 128'(1));
    check({tag, " out_valid after"}, 128'(out_valid), 128'(0));
    check({tag, " busy after"}, 128'(busy), 128'(0));
    if (exp_lat >= 0) check({tag, " latency"}, 128'(first_ov), 128'(exp_lat));
    @(negedge clk);
    check({tag, " done pulse width"}, 128'(done), 128'(0));
  endtask

  typedef struct packed {
    int  k;
    bit  gap;
    bit  stall;
    int  lat;
    logic [3:0][VW-1:0]  a;
    logic [3:0][VW-1:0]  b;
    logic [N-1:0][RW-1:0] exp;
  } vec_t;

  vec_t tbl [5];

  task automatic run_tbl(input int v);
    for (int kk = 0; kk < tbl[v].k; kk++) begin
      a_beats[kk] = tbl[v].a[kk];
      b_beats[kk] = tbl[v].b[kk];
    end
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(tbl[v].exp[i]);
    run_job($sformatf("tbl%0d", v), tbl[v].k, tbl[v].gap, tbl[v].stall, tbl[v].lat);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " in_ready"}, 128'(in_ready), 128'(0));
    check({tag, " out_valid"}, 128'(out_valid), 128'(0));
    check({tag, " out_idx"}, 128'(out_idx), 128'(0));
    check({tag, " out_row"}, 128'(out_row), 128'(0));
    check({tag, " busy"}, 128'(busy), 128'(0));
    check({tag, " done"}, 128'(done), 128'(0));
    check({tag, " state"}, 128'(fsm_state), 128'(0));
  endtask

  task automatic sat_test();
    int cyc;
    logic [15:0] e;
`ifdef SYSTOLIC_SATURATE_EN
    e = 16'h7fff;
`else
    e = 16'h0000;
`endif
    @(negedge clk);
    d2_start = 1'b1;
    d2_k_len = KW'(4);
    @(negedge clk);
    d2_start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      check("n2 in_ready", 128'(d2_in_ready), 128'(1));
      d2_in_valid = 1'b1;
      d2_a = 16'h8080;
      d2_b = 16'h8080;
      @(negedge clk);
    end
    d2_in_valid = 1'b0;
    cyc = 0;
    while (!d2_out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("n2 out_valid", 128'(d2_out_valid), 128'(1));
    for (int r = 0; r < 2; r++) begin
      check($sformatf("n2 idx%0d", r), 128'(d2_out_idx), 128'(r));
      check($sformatf("n2 row%0d", r), 128'(d2_out_row), 128'({e, e}));
      d2_out_ready = 1'b1;
      @(negedge clk);
    end
    d2_out_ready = 1'b0;
    check("n2 done", 128'(d2_done), 128'(1));
`ifdef SYSTOLIC_SATURATE_EN
    check("n2 sat_flag", 128'(d2_sat_flag), 128'(1));
`endif
  endtask

  // ---------------- test sequence ----------------
  initial begin
    for (int v = 0; v < 5; v++) tbl[v] = '0;
    tbl[0].k = 3; tbl[0].lat = 3 + 2 * N - 1;
    tbl[0].a[0] = v3(1, 0, 0); tbl[0].a[1] = v3(0, 1, 0); tbl[0].a[2] = v3(0, 0, 1);
    tbl[0].b[0] = v3(1, 2, 3); tbl[0].b[1] = v3(4, 5, 6); tbl[0].b[2] = v3(7, 8, 9);
    tbl[0].exp[0] = r3(1, 2, 3); tbl[0].exp[1] = r3(4, 5, 6); tbl[0].exp[2] = r3(7, 8, 9);
    tbl[1].k = 2; tbl[1].lat = 7;
    tbl[1].a[0] = v3(1, 3, 5); tbl[1].a[1] = v3(2, 4, 6);
    tbl[1].b[0] = v3(1, -1, 2); tbl[1].b[1] = v3(0, 3, -2);
    tbl[1].exp[0] = r3(1, 5, -2); tbl[1].exp[1] = r3(3, 9, -2); tbl[1].exp[2] = r3(5, 13, -2);
    tbl[2] = tbl[1]; tbl[2].gap = 1'b1; tbl[2].lat = -1;
    tbl[3] = tbl[0]; tbl[3].stall = 1'b1; tbl[3].lat = -1;
    tbl[4].k = 0; tbl[4].lat = -1;

    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    for (int v = 0; v < 5; v++) run_tbl(v);

    // Reset in the middle of a stream aborts the job immediately.
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(3);
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    a_vec = v3(9, 9, 9);
    b_vec = v3(9, 9, 9);
    @(negedge clk);
    check("mid busy", 128'(busy), 128'(1));
    #2 reset_n = 1'b0;
    #1 check_idle_outputs("mid reset");
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    run_tbl(0);
    run_tbl(4);

    for (int r = 0; r < 6; r++) begin
      int k;
      bit gap;
      k = $urandom_range(1, 8);
      gap = 1'($urandom_range(0, 1));
      for (int kk = 0; kk < k; kk++) begin
        a_beats[kk] = VW'($urandom);
        b_beats[kk] = VW'($urandom);
      end
      exp_q.delete();
      model_push(k);
      run_job($sformatf("rnd%0d", r), k, gap, (r == 5), (gap || r == 5) ? -1 : k + 2 * N - 1);
    end
`ifdef SYSTOLIC_SATURATE_EN
    check("sat_flag quiet", 128'(sat_flag), 128'(0));
`endif

    sat_test();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
